// File: rtl/croc_pkg.sv
// ============================================================================
// croc_pkg: shared types for the core memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package croc_pkg;

  typedef enum logic {
    SrcInstr = 1'b0,
    SrcData  = 1'b1
  } mem_src_e;

  localparam logic [3:0] c_INSTR_BE = 4'hF;

  function automatic mem_src_e other_src(input mem_src_e s);
    return (s == SrcInstr) ? SrcData : SrcInstr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_mem_arb_idq.sv
// ============================================================================
// core_mem_arb_idq: in-order FIFO of requester IDs for outstanding transactions
// Rev 1.0
// ============================================================================
`default_nettype none

module core_mem_arb_idq
  import croc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     i_push,
  input  mem_src_e i_src,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output mem_src_e o_head
);

  localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

  mem_src_e               r_mem [DEPTH];
  logic [c_PTR_W-1:0]     r_wptr;
  logic [c_PTR_W-1:0]     r_rptr;
  logic [c_CNT_W-1:0]     r_count;
  logic                   w_push;
  logic                   w_pop;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // Overflow/underflow requests are dropped so the count can never wrap.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_src;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_mem_arbiter.sv
// ============================================================================
// core_mem_arbiter: round-robin merge of instr/data OBI channels onto one port
// Rev 1.0
// ============================================================================
`default_nettype none

module core_mem_arbiter
  import croc_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  mem_src_e r_last;
  mem_src_e r_sel;
  logic     r_lock;

  mem_src_e w_sel;
  logic     w_sel_req;
  logic     w_req;
  logic     w_hs;
  logic     w_rsp;
  logic     w_full;
  logic     w_empty;
  mem_src_e w_head;

  // A stalled request keeps its selection; otherwise the non-last source wins ties.
  always_comb begin
    w_sel = SrcInstr;
    if (r_lock) begin
      w_sel = r_sel;
    end else if (instr_req_i && data_req_i) begin
      w_sel = other_src(r_last);
    end else if (data_req_i) begin
      w_sel = SrcData;
    end
  end

  assign w_sel_req = (w_sel == SrcData) ? data_req_i : instr_req_i;
  assign w_req     = rst_ni && !w_full && w_sel_req;
  assign w_hs      = w_req && mem_gnt_i;
  assign w_rsp     = rst_ni && mem_rvalid_i && !w_empty;

  assign mem_req_o   = w_req;
  assign instr_gnt_o = w_hs && (w_sel == SrcInstr);
  assign data_gnt_o  = w_hs && (w_sel == SrcData);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (rst_ni) begin
      if (w_sel == SrcData) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = c_INSTR_BE;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_rvalid_o = w_rsp && (w_head == SrcInstr);
  assign data_rvalid_o  = w_rsp && (w_head == SrcData);
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;
  assign instr_rdata_o  = rst_ni ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = rst_ni ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lock <= 1'b0;
      r_sel  <= SrcInstr;
      r_last <= SrcInstr;
    end else begin
      r_lock <= w_req && !mem_gnt_i;
      r_sel  <= w_sel;
      if (w_hs) begin
        r_last <= w_sel;
      end
    end
  end

  core_mem_arb_idq #(
    .DEPTH (MaxOutstanding)
  ) u_idq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_hs),
    .i_src   (w_sel),
    .i_pop   (w_rsp),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifndef SYNTHESIS
  a_rvalid_with_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !w_empty
  ) else $warning("core_mem_arbiter: mem_rvalid_i with no outstanding transaction");
`endif

endmodule

`default_nettype wire

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Arbitrates the core's separate instruction and data OBI-style request channels onto a single memory manager port, for SoC variants where the core shares one bus/SRAM port. The block sits between the core wrapper (cve2 instr_*/data_* ports) and the interconnect. It arbitrates with round-robin priority, tracks outstanding transactions in order, and routes each response back to the requester that issued it.

## Interface
- `MaxOutstanding`, default 2: maximum accepted-but-unanswered transactions (≥1).
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; **synchronous, active-low**.
- `instr_req_i`  in  1  instruction fetch request.
- `instr_addr_i`  in  32  fetch address.
- `instr_gnt_o`  out  1  fetch request accepted.
- `instr_rvalid_o`  out  1  fetch response valid.
- `instr_rdata_o`  out  32  fetch response data.
- `instr_err_o`  out  1  fetch response error.
- `data_req_i`  in  1  data request.
- `data_we_i`  in  1  write enable.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  32  data address.
- `data_wdata_i`  in  32  write data.
- `data_gnt_o`  out  1  data request accepted.
- `data_rvalid_o`  out  1  data response valid.
- `data_rdata_o`  out  32  data response data.
- `data_err_o`  out  1  data response error.
- `mem_req_o`  out  1  merged request.
- `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o`  out  1/4/32/32  merged request payload.
- `mem_gnt_i`  in  1  downstream grant.
- `mem_rvalid_i`  in  1  downstream response valid; responses return in request order.
- `mem_rdata_i`  in  32  response data.
- `mem_err_i`  in  1  response error.

## Operation
- A handshake completes when `mem_req_o && mem_gnt_i` are both high in the same cycle. The winner's `*_gnt_o` equals `mem_gnt_i` in that cycle; the loser's `*_gnt_o` is 0.
- Arbitration:
  - `last_q` records the last granted source.
  - When both sources request, the source that is not `last_q` wins.
  - `last_q` resets to INSTR, so data wins the first conflict.
  - `last_q` updates only on a completed handshake.
- Request lock:
  - If `mem_req_o` is high and `mem_gnt_i` is low, the selection is held (`lock_q`, `sel_q`) until the grant arrives.
  - While locked, the other source cannot preempt.
- Instruction payload is driven as `we`=0, `be`=4'hF, `wdata`=0, with `addr`=`instr_addr_i`.
- ID queue:
  - Each handshake pushes the winner ID into a FIFO of depth `MaxOutstanding`.
  - Each `mem_rvalid_i` pops the head.
  - The head ID steers `rvalid`, `rdata` and `err` to its owner.
  - The non-owner sees `rvalid`=0; `rdata` is broadcast and `err` is gated by ownership.
- Full: when count == `MaxOutstanding`, `mem_req_o` is 0 and both grants are 0, even if `mem_rvalid_i` pops in the same cycle. There is no bypass path from `rvalid` to `req`.
- A push and a pop in the same cycle (count < Max) leave the count unchanged and keep the ordering correct.
- `mem_rvalid_i` with an empty queue is a protocol violation: it is ignored (no output `rvalid`, no count change) and flagged by an assertion.
- Reset: sync, active-low.
  - Clears the queue, count, `lock_q`, and sets `last_q`=INSTR.
  - While `rst_ni`=0, all `req`/`gnt`/`rvalid`/`err` outputs are 0, and `mem_addr_o`/`mem_wdata_o`/`mem_be_o`/`mem_we_o` are 0.
  - A reset asserted mid-transaction discards outstanding IDs, so later responses are treated as empty-queue violations.

## Timing
- Request path is combinational: `*_req_i` → `mem_req_o` and payload have zero-cycle latency. `mem_gnt_i` → `*_gnt_o` is combinational.
- Response path is combinational: `mem_rvalid_i` → owner `*_rvalid_o` in the same cycle.
- Queue, count, `lock_q`, `sel_q` and `last_q` update on the `clk_i` rising edge.
- The block adds no pipeline stage. Back-to-back handshakes are possible every cycle until the queue is full.
- Requesters must hold `req` and payload stable until granted; the block relies on this rule.

## Structure
- Add a 1-bit `mem_src_e` {`SrcInstr`, `SrcData`} typedef to `croc_pkg`.
- One sub-module, `core_mem_arb_idq`: a parameterised in-order FIFO of `mem_src_e` with push, pop, full, empty and head outputs, using a `$clog2(MaxOutstanding+1)`-bit count.
- The top level holds the arbitration, lock, and muxing logic.

## Test plan
- **Single instr:** `instr_req`, addr 0x1000_0000, gnt same cycle, `rvalid` next cycle with rdata 0xDEADBEEF → `instr_gnt`=1, `instr_rvalid`=1, `instr_rdata`=0xDEADBEEF; `data_rvalid` stays 0.
- **Conflict:** both request from reset with `gnt`=1 → data granted cycle 0, instr cycle 1; responses route D then I, in order.
- **Lock:** both request with `gnt`=0 for 3 cycles, then 1 → selection never changes during the stall; the first grant goes to data.
- **Full:** `MaxOutstanding`=2 with no `rvalid` → after 2 handshakes, `mem_req_o`=0. An `rvalid` in cycle N re-enables `req` in cycle N+1, not N.
- **Error and simultaneous push/pop:** data write with `be`=4'b0011 and `err`=1 on response → `data_err_o`=1 and `instr_err_o`=0; the same-cycle push+pop leaves count at 1.
- **Reset mid-op:** 2 outstanding, `rst_ni`=0 for one cycle → all outputs 0 during reset; afterwards queue empty, and a stray `rvalid` produces no output `rvalid` and fires the assertion.
